// File: rtl/mem_req_controller.sv
// mem_req_controller: memory-side endpoint that queues mem_req, services it against a local SRAM and returns per-beat mem_rsp.
//
// Package mem_req_pkg (this file) defines request_t, shared with the interconnect.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-low reset
//   mem_req      request_t from interconnect (vld, core_id, we, addr, data, access_length used)
//   mem_rsp      request_t response (vld, core_id, we, addr, data driven; access_length 0)
//   busy         FIFO non-empty, FSM not IDLE, or a response still in the pipeline/output register
//   overflow     sticky flag: a valid request was dropped because the FIFO was full
//   fifo_level   current FIFO occupancy
//
// Build option
//   MEM_REQ_CTRL_WRITE_ACK_EN  when defined, each write returns one mem_rsp beat (we=1) with the
//                              same latency as a single-beat read; otherwise writes are posted.
//
// Pipeline: FIFO push (T) -> IDLE pop (T+1) -> LOAD (T+2) -> BURST access (T+3) -> mem_rsp (T+4).
package mem_req_pkg;
  typedef struct packed {
    logic        vld;
    logic [3:0]  core_id;
    logic        we;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  access_length;
  } request_t;
endpackage

module mem_req_controller
  import mem_req_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  request_t                      mem_req,
  output request_t                      mem_rsp,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]        core_id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        len;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] sram [MEM_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [1:0]        state;
  logic [3:0]        wk_core;
  logic              wk_we;
  logic [ADDR_W-1:0] wk_addr;
  logic [DATA_W-1:0] wk_data;
  logic [7:0]        beats;
  logic              p_vld, p_we;
  logic [3:0]        p_core;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              pop, push;
  entry_t            head;

  // A full FIFO still accepts a request when the head leaves in the same cycle.
  assign pop  = state == IDLE && fifo_level != '0;
  assign push = mem_req.vld && (fifo_level != LW'(FIFO_DEPTH) || pop);
  assign head = fifo_mem[rd_ptr];
  assign busy = fifo_level != '0 || state != IDLE || p_vld || mem_rsp.vld;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= '{mem_req.core_id, mem_req.we, mem_req.addr[ADDR_W-1:0], mem_req.data, mem_req.access_length};

  // Single-port SRAM: one access per BURST cycle; a write reports its own data for the optional ack.
  always_ff @(posedge clk)
    if (state == BURST) begin
      if (wk_we) sram[wk_addr[AW-1:0]] <= wk_data;
      p_data <= wk_we ? wk_data : sram[wk_addr[AW-1:0]];
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
      wk_core    <= '0;
      wk_we      <= 1'b0;
      wk_addr    <= '0;
      wk_data    <= '0;
      beats      <= '0;
      p_vld      <= 1'b0;
      p_we       <= 1'b0;
      p_core     <= '0;
      p_addr     <= '0;
      mem_rsp    <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      overflow   <= overflow | (mem_req.vld & ~push);
      state      <= pop ? LOAD : state == LOAD ? BURST : (state == BURST && beats == 8'd1) ? IDLE : state;
      if (pop) begin
        wk_core <= head.core_id;
        wk_we   <= head.we;
        wk_addr <= head.addr & AMASK;
        wk_data <= head.data;
        beats   <= head.len;
      end
      // Zero-length reads still take one beat; writes never burst.
      if (state == LOAD) beats <= (wk_we || beats == 8'd0) ? 8'd1 : beats;
      if (state == BURST) begin
        beats   <= beats - 8'd1;
        wk_addr <= (wk_addr + ADDR_W'(1)) & AMASK;
      end
      p_vld   <= state == BURST && (!wk_we || WR_ACK);
      p_we    <= wk_we;
      p_core  <= wk_core;
      p_addr  <= wk_addr;
      mem_rsp <= p_vld ? '{vld: 1'b1, core_id: p_core, we: p_we, addr: p_addr, data: p_data, access_length: 8'd0} : '0;
    end
endmodule

// File: tb/tb_mem_req_controller.sv
// tb_mem_req_controller: table-driven and scoreboard-checked bench for mem_req_controller.
module tb_mem_req_controller;
  import mem_req_pkg::*;
`ifdef MEM_REQ_CTRL_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  len;
    int          exp_beats;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  request_t    mem_req = '0;
  request_t    mem_rsp;
  logic        busy, overflow;
  logic [3:0]  fifo_level;
  int          tests = 0, fails = 0, cyc = 0, beats_seen = 0;
  request_t    sb [$];
  request_t    exp_rsp;
  int          beat_cyc [$];
  logic [63:0] model [1024];
  vec_t        vecs [13];

  mem_req_controller dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_rsp(mem_rsp),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (mem_rsp.vld) begin
      beats_seen++;
      beat_cyc.push_back(cyc);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp got %h required none", mem_rsp);
      end else begin
        exp_rsp = sb.pop_front();
        if (mem_rsp !== exp_rsp) begin
          fails++;
          $display("FAIL rsp_beat got %h required %h", mem_rsp, exp_rsp);
        end
      end
    end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_req(input logic we, input logic [3:0] core, input logic [15:0] addr, input logic [63:0] data, input logic [7:0] len);
    request_t e;
    int a, n;
    a = int'(addr) % 1024;
    if (we) begin
      model[a] = data;
      if (WACK) begin
        e = '0; e.vld = 1'b1; e.we = 1'b1; e.core_id = core; e.addr = 16'(a); e.data = data;
        sb.push_back(e);
      end
    end else begin
      n = (len == 8'd0) ? 1 : int'(len);
      for (int i = 0; i < n; i++) begin
        e = '0; e.vld = 1'b1; e.core_id = core; e.addr = 16'((a + i) % 1024); e.data = model[(a + i) % 1024];
        sb.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] core, input logic [15:0] addr, input logic [63:0] data, input logic [7:0] len);
    mem_req = '0;
    mem_req.vld = 1'b1; mem_req.we = we; mem_req.core_id = core;
    mem_req.addr = addr; mem_req.data = data; mem_req.access_length = len;
  endtask

  task automatic send(input logic we, input logic [3:0] core, input logic [15:0] addr, input logic [63:0] data, input logic [7:0] len);
    expect_req(we, core, addr, data, len);
    drive(we, core, addr, data, len);
    tick();
    mem_req = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 64'(n < 300), 64'd1);
  endtask

  initial begin
    int b0, t_req, n;
    vecs[0]  = '{1'b1, 4'd2, 16'h0010, 64'hAA,   8'd0, WACK ? 1 : 0};
    vecs[1]  = '{1'b0, 4'd2, 16'h0010, 64'h0,    8'd1, 1};
    vecs[2]  = '{1'b1, 4'd1, 16'h03FE, 64'd1,    8'd0, WACK ? 1 : 0};
    vecs[3]  = '{1'b1, 4'd1, 16'h03FF, 64'd2,    8'd0, WACK ? 1 : 0};
    vecs[4]  = '{1'b1, 4'd1, 16'h0000, 64'd3,    8'd0, WACK ? 1 : 0};
    vecs[5]  = '{1'b1, 4'd1, 16'h0001, 64'd4,    8'd0, WACK ? 1 : 0};
    vecs[6]  = '{1'b0, 4'd1, 16'h03FE, 64'h0,    8'd4, 4};
    vecs[7]  = '{1'b1, 4'd1, 16'h0412, 64'h55,   8'd0, WACK ? 1 : 0};
    vecs[8]  = '{1'b0, 4'd1, 16'h0012, 64'h0,    8'd1, 1};
    vecs[9]  = '{1'b0, 4'd3, 16'hFC12, 64'h0,    8'd1, 1};
    vecs[10] = '{1'b1, 4'd0, 16'h0021, 64'h77,   8'd0, WACK ? 1 : 0};
    vecs[11] = '{1'b1, 4'd0, 16'h0020, 64'hDEAD, 8'd5, WACK ? 1 : 0};
    vecs[12] = '{1'b0, 4'd0, 16'h0020, 64'h0,    8'd2, 2};

    drive(1'b0, 4'd1, 16'h0010, 64'h1234, 8'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_rsp", 64'(mem_rsp != '0), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      check("reset_level", 64'(fifo_level), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
    end
    mem_req = '0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      b0 = beats_seen;
      send(vecs[i].we, vecs[i].core, vecs[i].addr, vecs[i].data, vecs[i].len);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_beats", i), 64'(beats_seen - b0), 64'(vecs[i].exp_beats));
    end

    beat_cyc.delete();
    t_req = cyc + 1;
    send(1'b0, 4'd3, 16'h0010, 64'h0, 8'd0);
    wait_idle("len0");
    check("len0_beats", 64'(beat_cyc.size()), 64'd1);
    check("len0_latency", 64'(beat_cyc.size() > 0 ? beat_cyc[0] - t_req : -1), 64'd4);

    beat_cyc.delete();
    send(1'b0, 4'd1, 16'h03FE, 64'h0, 8'd4);
    wait_idle("wrap4");
    check("wrap4_contig", 64'(beat_cyc.size() == 4 ? beat_cyc[3] - beat_cyc[0] : -1), 64'd3);

    for (int i = 0; i < 11; i++) begin
      send(1'b1, 4'd0, 16'(16'h0100 + i), 64'(64'h1000 + i), 8'd0);
      wait_idle("preload");
    end

    b0 = beats_seen;
    for (int k = 0; k < 11; k++) begin
      if (k == 9) begin
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_no_overflow", 64'(overflow), 64'd0);
      end
      if (k == 0) expect_req(1'b0, 4'd1, 16'h0100, 64'h0, 8'd8);
      else if (k <= 8) expect_req(1'b0, 4'(k % 4), 16'(16'h0100 + k), 64'h0, 8'd1);
      drive(1'b0, k == 0 ? 4'd1 : 4'(k % 4), 16'(16'h0100 + k), 64'h0, k == 0 ? 8'd8 : 8'd1);
      tick();
    end
    mem_req = '0;
    check("overflow_set", 64'(overflow), 64'd1);
    wait_idle("overflow");
    check("overflow_beats", 64'(beats_seen - b0), 64'd16);
    check("overflow_sticky", 64'(overflow), 64'd1);

    send(1'b0, 4'd2, 16'h0100, 64'h0, 8'd8);
    b0 = beats_seen;
    n = 0;
    while (beats_seen - b0 < 3 && n < 100) begin
      tick();
      n++;
    end
    check("midburst_3beats", 64'(beats_seen - b0 >= 3), 64'd1);
    reset = 1'b0;
    sb.delete();
    #1;
    check("midburst_rsp_clr", 64'(mem_rsp != '0), 64'd0);
    tick();
    tick();
    check("midburst_overflow", 64'(overflow), 64'd0);
    check("midburst_level", 64'(fifo_level), 64'd0);
    check("midburst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    b0 = beats_seen;
    repeat (20) tick();
    check("post_reset_quiet", 64'(beats_seen - b0), 64'd0);
    b0 = beats_seen;
    send(1'b0, 4'd1, 16'h03FE, 64'h0, 8'd4);
    wait_idle("post_reset");
    check("post_reset_beats", 64'(beats_seen - b0), 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
